// File: rtl/mem_requester.sv
// Single-outstanding load/store initiator for a stall-capable, variable-latency data memory.
// Adds alignment checking and a bounded wait for completion.
module mem_requester #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_wr,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        req_ready,
   output logic        rsp_valid,
   output logic        rsp_err,
   output logic [15:0] rsp_rdata,
   output logic        mem_enable,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_data_in,
   input  logic [15:0] mem_data_out,
   input  logic        mem_stall,
   input  logic        mem_done
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

   state_t      state, state_next;
   logic        hold_wr, hold_wr_next;
   logic [15:0] hold_addr, hold_addr_next;
   logic [15:0] hold_wdata, hold_wdata_next;
   logic [15:0] rdata, rdata_next;
   logic        err, err_next;
   logic [7:0]  count, count_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         hold_wr    <= 1'b0;
         hold_addr  <= '0;
         hold_wdata <= '0;
         rdata      <= '0;
         err        <= 1'b0;
         count      <= '0;
      end else begin
         state      <= state_next;
         hold_wr    <= hold_wr_next;
         hold_addr  <= hold_addr_next;
         hold_wdata <= hold_wdata_next;
         rdata      <= rdata_next;
         err        <= err_next;
         count      <= count_next;
      end
   end

   always_comb begin
      state_next      = state;
      hold_wr_next    = hold_wr;
      hold_addr_next  = hold_addr;
      hold_wdata_next = hold_wdata;
      rdata_next      = rdata;
      err_next        = err;
      count_next      = count;
      unique case (state)
         IDLE: begin
            if (req_valid) begin
               hold_wr_next    = req_wr;
               hold_addr_next  = req_addr;
               hold_wdata_next = req_wdata;
               rdata_next      = '0;
               err_next        = req_addr[0];
               state_next      = req_addr[0] ? RESP : ISSUE;
            end
         end
         ISSUE: begin
            if (!mem_stall) begin
               count_next = '0;
               state_next = WAIT;
            end
         end
         WAIT: begin
            // completion on the final count takes priority over the timeout
            if (mem_done) begin
               rdata_next = hold_wr ? 16'h0000 : mem_data_out;
               state_next = RESP;
            end else if (count == LAST_COUNT) begin
               err_next   = 1'b1;
               rdata_next = '0;
               state_next = RESP;
            end else begin
               count_next = count + 8'd1;
            end
         end
         RESP: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      req_ready   = (state == IDLE);
      rsp_valid   = (state == RESP);
      rsp_err     = (state == RESP) ? err : 1'b0;
      rsp_rdata   = (state == RESP) ? rdata : '0;
      mem_enable  = (state == ISSUE);
      mem_wr      = (state == ISSUE) ? hold_wr : 1'b0;
      mem_addr    = (state == ISSUE || state == WAIT) ? hold_addr : '0;
      mem_data_in = (state == ISSUE || state == WAIT) ? hold_wdata : '0;
   end

endmodule

// File: tb/tb_mem_requester.sv
// Bench for mem_requester: vector table with scoreboarded responses plus reset and late-completion sequences.
module tb_mem_requester;

   localparam int unsigned T = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_wr = 1'b0;
   logic [15:0] req_addr = '0;
   logic [15:0] req_wdata = '0;
   logic        req_ready, rsp_valid, rsp_err, mem_enable, mem_wr;
   logic [15:0] rsp_rdata, mem_addr, mem_data_in;
   logic [15:0] mem_data_out = '0;
   logic        mem_stall = 1'b0;
   logic        mem_done = 1'b0;

   mem_requester #(.TIMEOUT(T)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
      .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
      .mem_data_out(mem_data_out), .mem_stall(mem_stall), .mem_done(mem_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [15:0] addr;
      logic [15:0] wdata;
      int unsigned stall;  // ISSUE stall cycles
      int unsigned dly;    // WAIT cycle index of mem_done; >= T means never
      logic [15:0] mdata;
      logic        err;
      logic [15:0] rdata;
   } vec_t;

   typedef struct {
      logic        err;
      logic [15:0] rdata;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endfunction

   always @(negedge clk) begin
      if (rsp_valid === 1'b1) begin
         if (sb.size() == 0) begin
            chk("spurious_rsp", {31'd0, rsp_valid}, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            chk("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, e.rdata});
         end
      end
   end

   task automatic run(input vec_t v);
      bit aligned, has_done, issue;
      int unsigned lat;
      exp_t e;
      aligned  = !v.addr[0];
      has_done = aligned && (v.dly < T);
      lat = !aligned ? 1 : (has_done ? 3 + v.stall + v.dly : 2 + v.stall + T);
      e.err = v.err;
      e.rdata = v.rdata;
      sb.push_back(e);
      @(posedge clk); #1;
      req_valid = 1'b1; req_wr = v.wr; req_addr = v.addr; req_wdata = v.wdata;
      mem_stall = 1'b0; mem_done = 1'b0;
      @(negedge clk);
      chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
      for (int unsigned c = 1; c <= lat + 1; c++) begin
         @(posedge clk); #1;
         req_valid = 1'b0;
         req_wr    = 1'($urandom);
         req_addr  = 16'($urandom);
         req_wdata = 16'($urandom);
         issue     = aligned && (c <= 1 + v.stall);
         mem_stall = issue ? (c <= v.stall) : 1'($urandom_range(0, 1));
         mem_done  = has_done && (c == 2 + v.stall + v.dly);
         mem_data_out = mem_done ? v.mdata : 16'($urandom);
         @(negedge clk);
         chk("mem_enable", {31'd0, mem_enable}, {31'd0, issue});
         if (issue) begin
            chk("mem_wr", {31'd0, mem_wr}, {31'd0, v.wr});
            chk("mem_addr", {16'd0, mem_addr}, {16'd0, v.addr});
            chk("mem_data_in", {16'd0, mem_data_in}, {16'd0, v.wdata});
         end
         chk("rsp_valid_timing", {31'd0, rsp_valid}, {31'd0, c == lat});
         chk("req_ready_timing", {31'd0, req_ready}, {31'd0, c == lat + 1});
      end
      mem_stall = 1'b0;
      mem_done  = 1'b0;
   endtask

   task automatic late_done();
      @(posedge clk); #1;
      mem_done = 1'b1; mem_data_out = 16'hDEAD;
      @(negedge clk);
      chk("late_done_rsp", {31'd0, rsp_valid}, 32'd0);
      @(posedge clk); #1;
      mem_done = 1'b0;
      @(negedge clk);
      chk("late_done_rsp2", {31'd0, rsp_valid}, 32'd0);
      chk("late_done_ready", {31'd0, req_ready}, 32'd1);
   endtask

   vec_t vecs[7];

   initial begin
      vecs[0] = '{1'b0, 16'h0010, 16'h0000, 0, 0,   16'hBEEF, 1'b0, 16'hBEEF};
      vecs[1] = '{1'b1, 16'h0020, 16'h1234, 3, 2,   16'h5A5A, 1'b0, 16'h0000};
      vecs[2] = '{1'b0, 16'h0021, 16'h0000, 0, 0,   16'h1111, 1'b1, 16'h0000};
      vecs[3] = '{1'b0, 16'h0040, 16'h0000, 0, 255, 16'h2222, 1'b1, 16'h0000};
      vecs[4] = '{1'b0, 16'h0042, 16'h0000, 1, 3,   16'hCAFE, 1'b0, 16'hCAFE};
      vecs[5] = '{1'b1, 16'hFFFF, 16'hAAAA, 0, 0,   16'h3333, 1'b1, 16'h0000};
      vecs[6] = '{1'b0, 16'hFFFE, 16'h0000, 2, 1,   16'h8001, 1'b0, 16'h8001};

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      chk("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
      chk("rst_mem_enable", {31'd0, mem_enable}, 32'd0);
      chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
      chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
      chk("rst_mem_data_in", {16'd0, mem_data_in}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 7; i++) begin
         run(vecs[i]);
         if (i == 3) late_done();
      end

      // reset while waiting for completion; a later mem_done must not produce a response
      @(posedge clk); #1;
      req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0100; mem_stall = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("rw_issue_en", {31'd0, mem_enable}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("rw_wait_en", {31'd0, mem_enable}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; mem_done = 1'b1; mem_data_out = 16'h7777;
      @(negedge clk);
      chk("rw_ready", {31'd0, req_ready}, 32'd1);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         mem_done = 1'b0;
         @(negedge clk);
         chk("rw_no_rsp", {31'd0, rsp_valid}, 32'd0);
      end

      // reset during a stalled ISSUE: enable drops the following cycle
      @(posedge clk); #1;
      req_valid = 1'b1; req_wr = 1'b1; req_addr = 16'h0200; req_wdata = 16'h0F0F;
      @(posedge clk); #1;
      req_valid = 1'b0; mem_stall = 1'b1; rst = 1'b1;
      @(negedge clk);
      chk("ri_issue_en", {31'd0, mem_enable}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b0; mem_stall = 1'b0;
      @(negedge clk);
      chk("ri_en_drop", {31'd0, mem_enable}, 32'd0);
      chk("ri_ready", {31'd0, req_ready}, 32'd1);

      run(vecs[0]);
      run(vecs[1]);

      repeat (2) @(posedge clk);
      chk("sb_empty", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
